ex_mem_stage: RTL and testbench
===============================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameters SHALL be: DATA_W, 32, datapath width; REG_W, 5, register-index width.
REQ-002 Clock is single; reset is synchronous and active-high. Ports SHALL be, clock and reset first:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold EX/MEM contents
- flush  in  1  kill the instruction being captured
- ex_valid  in  1  EX slot holds a real instruction
- ex_pc  in  32  PC of the EX instruction
- ex_bd  in  1  EX instruction is in a branch delay slot
- alu_r  in  32  ALU result
- alu_overflow  in  1  ALU overflow flag; meaningful only for signed add/sub, may be Z otherwise
- ex_ovf_chk  in  1  instruction is add/addi/sub
- ex_mem_rd  in  1  load
- ex_mem_wr  in  1  store
- ex_reg_wr  in  1  register writeback
- ex_rd  in  REG_W  destination register
- ex_store_data  in  32  store data
- exc_ack  in  1  CP0 has taken the exception
- mem_valid  out  1  registered valid
- mem_alu_r  out  32  registered result
- mem_store_data  out  32  registered store data
- mem_rd  out  REG_W  registered destination
- mem_reg_wr, mem_mem_rd, mem_mem_wr  out  1 each  registered controls
- exc_req  out  1  exception pending to CP0
- exc_cause  out  5  ExcCode: 12 = Ov, 4 = AdEL, 5 = AdES
- exc_epc  out  32  exception PC
- exc_bd_o  out  1  BD bit for CP0
- flush_up  out  1  kill IF/ID/EX

Function
REQ-003 Capture: on a rising edge with stall=0, all mem_* registers SHALL load from the ex_* inputs, giving 1-cycle latency.
REQ-004 Stall: with stall=1 and flush=0, every mem_* output SHALL hold its value, and no exception SHALL be detected that cycle.
REQ-005 Flush: with flush=1, the next mem_valid, mem_reg_wr, mem_mem_rd and mem_mem_wr SHALL be 0; flush SHALL win over stall.
REQ-006 alu_overflow SHALL be sampled only when ex_ovf_chk=1. Any other time, including when it is Z or X, it SHALL be treated as 0.
REQ-007 ovf_exc is defined as ex_valid & ex_ovf_chk & alu_overflow. It SHALL be evaluated only on a capture edge, with stall=0, flush=0 and the FSM in RUN.
REQ-008 FSM states SHALL be RUN and EXC_WAIT. Reset state is RUN.
REQ-009 Transition RUN->EXC_WAIT SHALL occur on a capture edge where an exception is detected. On that edge:
- mem_valid and all mem_* write enables SHALL load 0, cancelling the instruction.
- exc_req SHALL load 1.
- exc_cause SHALL load the cause.
- exc_epc SHALL load ex_bd ? ex_pc-4 : ex_pc, using 32-bit wrap-around subtraction.
- exc_bd_o SHALL load ex_bd.
REQ-010 flush_up SHALL be asserted combinationally in the same cycle an exception is detected, and continuously while in EXC_WAIT.
REQ-011 In EXC_WAIT, captures SHALL load bubbles (mem_valid=0, enables 0), and exc_req/exc_cause/exc_epc/exc_bd_o SHALL hold.
REQ-012 Transition EXC_WAIT->RUN SHALL occur on the edge where exc_ack=1. exc_req SHALL be 0 from the following cycle.
REQ-013 exc_ack SHALL be ignored in RUN.
REQ-014 A new exception SHALL NOT be detected in the cycle ack is sampled.
REQ-015 Only one exception SHALL be pending at a time.

Reset
REQ-016 When rst=1 at a rising edge, every output register SHALL go to 0 and the FSM to RUN, including mid-EXC_WAIT. rst SHALL take priority over stall, flush and exc_ack.
REQ-017 flush_up SHALL be 0 during reset.

Configuration
REQ-018 Macro MEM_ALIGN_CHK_EN SHALL enable word-alignment checking.
- Defined: alu_r[1:0]!=0 with ex_mem_rd raises cause 4; with ex_mem_wr it raises cause 5. Detection follows the same conditions as REQ-007.
- Overflow priority: if both overflow and misalignment are detected on the same capture, overflow (cause 12) SHALL take priority.
- Not defined: no alignment logic is present, and only cause 12 is ever produced.

Structure
REQ-019 A shared package SHALL hold:
- ExcCode constants (EXC_OV=12, EXC_ADEL=4, EXC_ADES=5)
- the FSM state typedef
- DATA_W/REG_W defaults
REQ-020 One sub-module, exc_detect, SHALL be combinational. It SHALL take the ex_* signals, produce exc_hit and the cause, and own the macro-guarded logic.

Verification
REQ-021 Normal capture: alu_r=0x0000_0010, ex_rd=5, ex_reg_wr=1, ex_valid=1 -> next cycle mem_alu_r=0x10, mem_rd=5, mem_valid=1, exc_req=0.
REQ-022 Overflow: ex_ovf_chk=1, alu_overflow=1, ex_pc=0x0040_0020, ex_bd=0 -> next cycle exc_req=1, exc_cause=12, exc_epc=0x0040_0020, mem_valid=0, mem_reg_wr=0; flush_up=1 in the detect cycle and until ack.
REQ-023 Delay slot plus ack timing: overflow with ex_bd=1 and ex_pc=0x0040_0024 -> exc_epc=0x0040_0020, exc_bd_o=1. exc_ack=1 two cycles later -> exc_req=0 one cycle after the ack edge.
REQ-024 Z-overflow gating: alu_overflow=Z, ex_ovf_chk=0 -> no exception. Then stall=1 with flush=1 -> mem_valid=0 next cycle.
REQ-025 Alignment:
- With MEM_ALIGN_CHK_EN defined: ex_mem_wr=1, alu_r=0x1002 -> exc_cause=5.
- Without the macro, the same stimulus -> mem_mem_wr=1, no exception.
- Reset asserted during EXC_WAIT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the EX/MEM pipeline stage: exception codes, FSM
// state type and default widths.
package ex_mem_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;

  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    EXC_WAIT = 1'b1
  } state_e;

  // EPC points at the branch when the faulting instruction sits in its delay slot.
  function automatic logic [31:0] calc_epc(input logic [31:0] pc, input logic bd);
    calc_epc = bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/ex_mem_stage_exc_detect.sv
// Combinational exception detector for the EX/MEM stage. Word-alignment
// checking of loads/stores is present only when MEM_ALIGN_CHK_EN is defined.
module exc_detect
  import ex_mem_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              detect_en,
  input  logic              ex_valid,
  input  logic              ex_ovf_chk,
  input  logic              alu_overflow,
  input  logic              ex_mem_rd,
  input  logic              ex_mem_wr,
  input  logic [DATA_W-1:0] alu_r,
  output logic              exc_hit,
  output logic [4:0]        exc_cause
);

  logic ovf_hit;

  // ex_ovf_chk gates the flag first so an undriven overflow line reads as 0.
  assign ovf_hit = detect_en & ex_valid & ex_ovf_chk & alu_overflow;

`ifdef MEM_ALIGN_CHK_EN
  logic misaligned;
  logic ld_hit;
  logic st_hit;

  assign misaligned = (alu_r[1:0] != 2'b00);
  assign ld_hit     = detect_en & ex_valid & ex_mem_rd & misaligned;
  assign st_hit     = detect_en & ex_valid & ex_mem_wr & misaligned;

  always_comb begin
    exc_hit   = ovf_hit | ld_hit | st_hit;
    exc_cause = EXC_OV;
    if (ovf_hit) begin
      exc_cause = EXC_OV;
    end else if (ld_hit) begin
      exc_cause = EXC_ADEL;
    end else if (st_hit) begin
      exc_cause = EXC_ADES;
    end
  end
`else
  logic unused_align_inputs;
  assign unused_align_inputs = ^{ex_mem_rd, ex_mem_wr, alu_r};

  always_comb begin
    exc_hit   = ovf_hit;
    exc_cause = EXC_OV;
  end
`endif

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with overflow (and, under MEM_ALIGN_CHK_EN,
// address-alignment) exception capture and a RUN/EXC_WAIT handshake to CP0.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [31:0]       ex_pc,
  input  logic              ex_bd,
  input  logic [DATA_W-1:0] alu_r,
  input  logic              alu_overflow,
  input  logic              ex_ovf_chk,
  input  logic              ex_mem_rd,
  input  logic              ex_mem_wr,
  input  logic              ex_reg_wr,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic              exc_ack,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_alu_r,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_W-1:0]  mem_rd,
  output logic              mem_reg_wr,
  output logic              mem_mem_rd,
  output logic              mem_mem_wr,
  output logic              exc_req,
  output logic [4:0]        exc_cause,
  output logic [31:0]       exc_epc,
  output logic              exc_bd_o,
  output logic              flush_up
);

  state_e            state_q, state_d;
  logic              mem_valid_q, mem_valid_d;
  logic [DATA_W-1:0] mem_alu_r_q, mem_alu_r_d;
  logic [DATA_W-1:0] mem_store_data_q, mem_store_data_d;
  logic [REG_W-1:0]  mem_rd_q, mem_rd_d;
  logic              mem_reg_wr_q, mem_reg_wr_d;
  logic              mem_mem_rd_q, mem_mem_rd_d;
  logic              mem_mem_wr_q, mem_mem_wr_d;
  logic              exc_req_q, exc_req_d;
  logic [4:0]        exc_cause_q, exc_cause_d;
  logic [31:0]       exc_epc_q, exc_epc_d;
  logic              exc_bd_q, exc_bd_d;

  logic              detect_en;
  logic              exc_hit;
  logic [4:0]        hit_cause;

  // Detection only on a genuine capture while no exception is outstanding.
  assign detect_en = ~stall & ~flush & (state_q == RUN);

  exc_detect #(
    .DATA_W (DATA_W)
  ) u_exc_detect (
    .detect_en    (detect_en),
    .ex_valid     (ex_valid),
    .ex_ovf_chk   (ex_ovf_chk),
    .alu_overflow (alu_overflow),
    .ex_mem_rd    (ex_mem_rd),
    .ex_mem_wr    (ex_mem_wr),
    .alu_r        (alu_r),
    .exc_hit      (exc_hit),
    .exc_cause    (hit_cause)
  );

  always_comb begin
    state_d          = state_q;
    mem_valid_d      = mem_valid_q;
    mem_alu_r_d      = mem_alu_r_q;
    mem_store_data_d = mem_store_data_q;
    mem_rd_d         = mem_rd_q;
    mem_reg_wr_d     = mem_reg_wr_q;
    mem_mem_rd_d     = mem_mem_rd_q;
    mem_mem_wr_d     = mem_mem_wr_q;
    exc_req_d        = exc_req_q;
    exc_cause_d      = exc_cause_q;
    exc_epc_d        = exc_epc_q;
    exc_bd_d         = exc_bd_q;

    if (!stall) begin
      mem_alu_r_d      = alu_r;
      mem_store_data_d = ex_store_data;
      mem_rd_d         = ex_rd;
    end

    // Flush beats stall; an excepting or post-exception capture becomes a bubble.
    if (flush) begin
      mem_valid_d  = 1'b0;
      mem_reg_wr_d = 1'b0;
      mem_mem_rd_d = 1'b0;
      mem_mem_wr_d = 1'b0;
    end else if (!stall) begin
      if (exc_hit || (state_q == EXC_WAIT)) begin
        mem_valid_d  = 1'b0;
        mem_reg_wr_d = 1'b0;
        mem_mem_rd_d = 1'b0;
        mem_mem_wr_d = 1'b0;
      end else begin
        mem_valid_d  = ex_valid;
        mem_reg_wr_d = ex_reg_wr;
        mem_mem_rd_d = ex_mem_rd;
        mem_mem_wr_d = ex_mem_wr;
      end
    end

    unique case (state_q)
      RUN: begin
        if (exc_hit) begin
          state_d     = EXC_WAIT;
          exc_req_d   = 1'b1;
          exc_cause_d = hit_cause;
          exc_epc_d   = calc_epc(ex_pc, ex_bd);
          exc_bd_d    = ex_bd;
        end
      end
      EXC_WAIT: begin
        if (exc_ack) begin
          state_d   = RUN;
          exc_req_d = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= RUN;
      mem_valid_q      <= 1'b0;
      mem_alu_r_q      <= '0;
      mem_store_data_q <= '0;
      mem_rd_q         <= '0;
      mem_reg_wr_q     <= 1'b0;
      mem_mem_rd_q     <= 1'b0;
      mem_mem_wr_q     <= 1'b0;
      exc_req_q        <= 1'b0;
      exc_cause_q      <= '0;
      exc_epc_q        <= '0;
      exc_bd_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      mem_valid_q      <= mem_valid_d;
      mem_alu_r_q      <= mem_alu_r_d;
      mem_store_data_q <= mem_store_data_d;
      mem_rd_q         <= mem_rd_d;
      mem_reg_wr_q     <= mem_reg_wr_d;
      mem_mem_rd_q     <= mem_mem_rd_d;
      mem_mem_wr_q     <= mem_mem_wr_d;
      exc_req_q        <= exc_req_d;
      exc_cause_q      <= exc_cause_d;
      exc_epc_q        <= exc_epc_d;
      exc_bd_q         <= exc_bd_d;
    end
  end

  assign flush_up       = ~rst & (exc_hit | (state_q == EXC_WAIT));
  assign mem_valid      = mem_valid_q;
  assign mem_alu_r      = mem_alu_r_q;
  assign mem_store_data = mem_store_data_q;
  assign mem_rd         = mem_rd_q;
  assign mem_reg_wr     = mem_reg_wr_q;
  assign mem_mem_rd     = mem_mem_rd_q;
  assign mem_mem_wr     = mem_mem_wr_q;
  assign exc_req        = exc_req_q;
  assign exc_cause      = exc_cause_q;
  assign exc_epc        = exc_epc_q;
  assign exc_bd_o       = exc_bd_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: directed vectors push expected results,
// a negedge monitor pops and compares. Expectations follow MEM_ALIGN_CHK_EN.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, ex_valid, ex_bd, alu_overflow, ex_ovf_chk;
  logic        ex_mem_rd, ex_mem_wr, ex_reg_wr, exc_ack;
  logic [31:0] ex_pc, alu_r, ex_store_data;
  logic [4:0]  ex_rd;
  logic        mem_valid, mem_reg_wr, mem_mem_rd, mem_mem_wr;
  logic [31:0] mem_alu_r, mem_store_data, exc_epc;
  logic [4:0]  mem_rd, exc_cause;
  logic        exc_req, exc_bd_o, flush_up;

  always #5 clk = ~clk;

  ex_mem_stage #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_bd(ex_bd), .alu_r(alu_r),
    .alu_overflow(alu_overflow), .ex_ovf_chk(ex_ovf_chk),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_reg_wr(ex_reg_wr),
    .ex_rd(ex_rd), .ex_store_data(ex_store_data), .exc_ack(exc_ack),
    .mem_valid(mem_valid), .mem_alu_r(mem_alu_r), .mem_store_data(mem_store_data),
    .mem_rd(mem_rd), .mem_reg_wr(mem_reg_wr), .mem_mem_rd(mem_mem_rd),
    .mem_mem_wr(mem_mem_wr), .exc_req(exc_req), .exc_cause(exc_cause),
    .exc_epc(exc_epc), .exc_bd_o(exc_bd_o), .flush_up(flush_up)
  );

  typedef struct packed {
    logic        rst, stall, flush, valid;
    logic [31:0] pc;
    logic        bd;
    logic [31:0] alu;
    logic        ovf_z, ovf, chk, mrd, mwr, rwr;
    logic [4:0]  rd;
    logic [31:0] sd;
    logic        ack;
  } stim_t;

  typedef struct packed {
    logic        fu;
    logic        dc;      // data fields unchecked
    logic        valid;
    logic [31:0] alu, sd;
    logic [4:0]  rd;
    logic        rwr, mrd, mwr, req;
    logic [4:0]  cause;
    logic [31:0] epc;
    logic        bd;
  } exp_t;

  typedef struct {
    exp_t e;
    int   cyc;
    int   step;
  } ent_t;

  ent_t qc[$];
  ent_t qr[$];
  int   cyc_cnt = 0;
  int   checks  = 0;
  int   errors  = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input int step, input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL step %0d %s: got %h expected %h", step, nm, act, exp);
    end
  endtask

  task automatic apply(input stim_t s, input exp_t e, input int step);
    ent_t en;
    @(posedge clk);
    #1;
    rst = s.rst; stall = s.stall; flush = s.flush; ex_valid = s.valid;
    ex_pc = s.pc; ex_bd = s.bd; alu_r = s.alu; ex_ovf_chk = s.chk;
    alu_overflow = s.ovf_z ? 1'bz : s.ovf;
    ex_mem_rd = s.mrd; ex_mem_wr = s.mwr; ex_reg_wr = s.rwr; ex_rd = s.rd;
    ex_store_data = s.sd; exc_ack = s.ack;
    en.e = e; en.cyc = cyc_cnt; en.step = step;
    qc.push_back(en);
    qr.push_back(en);
  endtask

  ent_t mc, mr;
  always @(negedge clk) begin
    if (qc.size() > 0 && qc[0].cyc == cyc_cnt) begin
      mc = qc.pop_front();
      chk(mc.step, "flush_up", {31'd0, flush_up}, {31'd0, mc.e.fu});
    end
    if (qr.size() > 0 && qr[0].cyc < cyc_cnt) begin
      mr = qr.pop_front();
      chk(mr.step, "mem_valid", {31'd0, mem_valid}, {31'd0, mr.e.valid});
      chk(mr.step, "mem_reg_wr", {31'd0, mem_reg_wr}, {31'd0, mr.e.rwr});
      chk(mr.step, "mem_mem_rd", {31'd0, mem_mem_rd}, {31'd0, mr.e.mrd});
      chk(mr.step, "mem_mem_wr", {31'd0, mem_mem_wr}, {31'd0, mr.e.mwr});
      chk(mr.step, "exc_req", {31'd0, exc_req}, {31'd0, mr.e.req});
      chk(mr.step, "exc_cause", {27'd0, exc_cause}, {27'd0, mr.e.cause});
      chk(mr.step, "exc_epc", exc_epc, mr.e.epc);
      chk(mr.step, "exc_bd_o", {31'd0, exc_bd_o}, {31'd0, mr.e.bd});
      if (!mr.e.dc) begin
        chk(mr.step, "mem_alu_r", mem_alu_r, mr.e.alu);
        chk(mr.step, "mem_store_data", mem_store_data, mr.e.sd);
        chk(mr.step, "mem_rd", {27'd0, mem_rd}, {27'd0, mr.e.rd});
      end
    end
  end

  initial begin
    stim_t s;
    exp_t  e;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; ex_valid = 1'b0; ex_pc = '0;
    ex_bd = 1'b0; alu_r = '0; alu_overflow = 1'b0; ex_ovf_chk = 1'b0;
    ex_mem_rd = 1'b0; ex_mem_wr = 1'b0; ex_reg_wr = 1'b0; ex_rd = '0;
    ex_store_data = '0; exc_ack = 1'b0;

    // 0: reset
    s = '0; s.rst = 1; e = '0;
    apply(s, e, 0);
    // 1: normal ALU capture
    s = '0; s.valid = 1; s.alu = 32'h10; s.rd = 5; s.rwr = 1; s.sd = 32'hdead_beef;
    e = '0; e.valid = 1; e.alu = 32'h10; e.rd = 5; e.rwr = 1; e.sd = 32'hdead_beef;
    apply(s, e, 1);
    // 2: aligned load
    s = '0; s.valid = 1; s.alu = 32'h100; s.mrd = 1; s.rwr = 1; s.rd = 7;
    e = '0; e.valid = 1; e.alu = 32'h100; e.mrd = 1; e.rwr = 1; e.rd = 7;
    apply(s, e, 2);
    // 3: stall holds and suppresses an overflowing instruction
    s = '0; s.stall = 1; s.valid = 1; s.alu = 32'h999; s.chk = 1; s.ovf = 1; s.rd = 1;
    apply(s, e, 3);
    // 4: overflow, not in delay slot
    s = '0; s.valid = 1; s.chk = 1; s.ovf = 1; s.pc = 32'h0040_0020;
    s.alu = 32'h7fff_ffff; s.rwr = 1; s.rd = 3;
    e = '0; e.fu = 1; e.alu = 32'h7fff_ffff; e.rd = 3; e.req = 1; e.cause = 5'd12;
    e.epc = 32'h0040_0020;
    apply(s, e, 4);
    // 5: EXC_WAIT turns a capture into a bubble, exception regs hold
    s = '0; s.valid = 1; s.rwr = 1; s.alu = 32'h55; s.rd = 9;
    e.alu = 32'h55; e.rd = 9;
    apply(s, e, 5);
    // 6: ack returns to RUN
    s = '0; s.ack = 1;
    e.alu = 0; e.rd = 0; e.req = 0;
    apply(s, e, 6);
    // 7: ack ignored in RUN
    s = '0; s.ack = 1; s.valid = 1; s.rwr = 1; s.alu = 32'h20; s.rd = 4;
    e.fu = 0; e.valid = 1; e.rwr = 1; e.alu = 32'h20; e.rd = 4;
    apply(s, e, 7);
    // 8: overflow in delay slot, EPC backs up to the branch
    s = '0; s.valid = 1; s.chk = 1; s.ovf = 1; s.bd = 1; s.pc = 32'h0040_0024;
    s.alu = 32'h8000_0000; s.rwr = 1; s.rd = 2;
    e = '0; e.fu = 1; e.alu = 32'h8000_0000; e.rd = 2; e.req = 1; e.cause = 5'd12;
    e.epc = 32'h0040_0020; e.bd = 1;
    apply(s, e, 8);
    // 9: waiting
    s = '0;
    e.alu = 0; e.rd = 0;
    apply(s, e, 9);
    // 10: ack with an overflowing instruction present: no new exception
    s = '0; s.ack = 1; s.valid = 1; s.chk = 1; s.ovf = 1; s.pc = 32'h100; s.alu = 32'h1;
    e.alu = 32'h1; e.req = 0;
    apply(s, e, 10);
    // 11: Z overflow with check disabled
    s = '0; s.valid = 1; s.ovf_z = 1; s.alu = 32'h30; s.rwr = 1; s.rd = 6;
    e.fu = 0; e.valid = 1; e.rwr = 1; e.alu = 32'h30; e.rd = 6;
    apply(s, e, 11);
    // 12: stall and flush together, flush wins
    s = '0; s.stall = 1; s.flush = 1; s.valid = 1; s.rwr = 1; s.alu = 32'h40; s.rd = 8;
    e.dc = 1; e.valid = 0; e.rwr = 0;
    apply(s, e, 12);
    // 13: flush suppresses overflow detection
    s = '0; s.flush = 1; s.valid = 1; s.chk = 1; s.ovf = 1; s.pc = 32'h200; s.rwr = 1;
    apply(s, e, 13);
    // 14: misaligned store
    s = '0; s.valid = 1; s.mwr = 1; s.alu = 32'h1002; s.sd = 32'hcafe; s.pc = 32'h0040_0100;
    e.dc = 0; e.alu = 32'h1002; e.sd = 32'hcafe; e.rd = 0;
`ifdef MEM_ALIGN_CHK_EN
    e.fu = 1; e.valid = 0; e.mwr = 0; e.req = 1; e.cause = 5'd5;
    e.epc = 32'h0040_0100; e.bd = 0;
`else
    e.fu = 0; e.valid = 1; e.mwr = 1; e.req = 0;
`endif
    apply(s, e, 14);
    // 15: reset beats stall and ack (mid EXC_WAIT when alignment checking is on)
    s = '0; s.rst = 1; s.stall = 1; s.ack = 1; s.valid = 1; s.rwr = 1; s.alu = 32'h77;
    e = '0;
    apply(s, e, 15);
    // 16: misaligned load
    s = '0; s.valid = 1; s.mrd = 1; s.rwr = 1; s.rd = 10; s.alu = 32'h1001; s.pc = 32'h200;
    e = '0; e.alu = 32'h1001; e.rd = 10;
`ifdef MEM_ALIGN_CHK_EN
    e.fu = 1; e.req = 1; e.cause = 5'd4; e.epc = 32'h200;
`else
    e.valid = 1; e.mrd = 1; e.rwr = 1;
`endif
    apply(s, e, 16);
    // 17: ack
    s = '0; s.ack = 1;
`ifdef MEM_ALIGN_CHK_EN
    e = '0; e.fu = 1; e.cause = 5'd4; e.epc = 32'h200;
`else
    e = '0;
`endif
    apply(s, e, 17);
    // 18: overflow and misaligned load together, overflow wins
    s = '0; s.valid = 1; s.chk = 1; s.ovf = 1; s.mrd = 1; s.alu = 32'h3; s.pc = 32'h300;
    s.rd = 11; s.rwr = 1;
    e = '0; e.fu = 1; e.alu = 32'h3; e.rd = 11; e.req = 1; e.cause = 5'd12; e.epc = 32'h300;
    apply(s, e, 18);
    // 19: reset during EXC_WAIT
    s = '0; s.rst = 1; s.ack = 1; s.stall = 1;
    e = '0;
    apply(s, e, 19);
    // 20: idle after reset
    s = '0;
    apply(s, e, 20);

    s = '0;
    apply(s, e, 21);
    for (int i = 0; i < 10 && (qc.size() > 0 || qr.size() > 0); i++) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (qc.size() != 0 || qr.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d entries left expected 0/0", qc.size(), qr.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
